// File: rtl/axi_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_master_pkg
//  Description : Shared types and constants for the AXI master command
//                decoder: controller state encoding, AXI burst and response
//                codes, fixed AxLOCK/AxCACHE/AxPROT attributes and the WRAP
//                length legality check.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_master_pkg;

    // Controller states; only one transaction is ever in flight.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        WR_DATA  = 3'd2,
        WR_RESP  = 3'd3,
        RD_ISSUE = 3'd4,
        RD_DATA  = 3'd5
    } state_t;

    // AXI burst type codes
    localparam logic [1:0] c_BURST_FIXED = 2'b00;
    localparam logic [1:0] c_BURST_INCR  = 2'b01;
    localparam logic [1:0] c_BURST_WRAP  = 2'b10;

    // AXI response codes
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    // Fixed transaction attributes driven on both address channels
    localparam logic [1:0] c_AXLOCK  = 2'b00;
    localparam logic [1:0] c_AXCACHE = 2'b00;
    localparam logic [2:0] c_AXPROT  = 3'b000;

    // Response entry overhead beyond the data field: is_read + id + resp + last
    localparam int c_RSP_META_W = 8;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_legal(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage : axi_master_pkg
`default_nettype wire

// File: rtl/axi_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axi_rsp_fifo
//  Description : Synchronous FIFO holding response entries. A push into a
//                full FIFO is dropped and sets a sticky overflow flag, unless
//                a pop happens in the same cycle, in which case both succeed.
//  Ports       : clk_i/rst_i   clock, asynchronous active-high reset
//                push_i/push_data_i   write side
//                pop_i/pop_data_o     read side (pop_data_o = head entry)
//                empty_o              no entries stored
//                overflow_o           sticky, an entry was dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4     // power of two, >= 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             empty_o,
    output logic             overflow_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             overflow_q;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (count_q == '0);
    assign w_full    = (count_q == (AW+1)'(DEPTH));
    assign w_do_pop  = pop_i && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_do_push = push_i && (!w_full || w_do_pop);

    // Storage carries no reset; validity is tracked by the count.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (push_i && !w_do_push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign empty_o    = w_empty;
    assign overflow_o = overflow_q;

endmodule : axi_rsp_fifo
`default_nettype wire

// File: rtl/axi_master_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : axi_master_decoder
//  Description : Turns a simple command stream into single-outstanding AXI
//                write/read requests for a downstream master, forwards write
//                data beats, and collects write responses and read beats into
//                a response FIFO. Illegal WRAP lengths are answered locally
//                with SLVERR and never issued.
//  Ports       : AClk/ARst                 clock, async active-high reset
//                cmd_*                     command stream (valid/ready)
//                wd_*                      write-data stream (valid/ready)
//                wbeat_ack                 master accepted a W beat
//                aw*/wdata_d/wstrb_d/...   write request to master
//                bresp_d/bid_d/wr_rsp_en_d write response from master
//                ar*/rd_trn_en             read request to master
//                rdata_d/rresp_d/rid_d/... read beats from master
//                rsp_*                     response stream (valid/ready)
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_master_decoder
    import axi_master_pkg::*;
#(
    parameter int addr_width = 32,
    parameter int data_width = 64,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  AClk,
    input  logic                  ARst,
    // command stream
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rw,
    input  logic [3:0]            cmd_id,
    input  logic [addr_width-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [1:0]            cmd_burst,
    // write-data stream
    input  logic                  wd_valid,
    output logic                  wd_ready,
    input  logic [data_width-1:0] wd_data,
    input  logic [7:0]            wd_strb,
    input  logic                  wbeat_ack,
    // write request to master
    output logic [3:0]            TXN_ID_W_d,
    output logic [addr_width-1:0] awaddr_d,
    output logic [7:0]            awlen_d,
    output logic [2:0]            awsize_d,
    output logic [1:0]            awburst_d,
    output logic [1:0]            awlock_d,
    output logic [1:0]            awcache_d,
    output logic [2:0]            awprot_d,
    output logic [data_width-1:0] wdata_d,
    output logic [7:0]            wstrb_d,
    output logic                  wr_trn_en,
    // write response from master
    input  logic [1:0]            bresp_d,
    input  logic [3:0]            bid_d,
    input  logic                  wr_rsp_en_d,
    // read request to master
    output logic [3:0]            TXN_ID_R_d,
    output logic [addr_width-1:0] araddr_d,
    output logic [7:0]            arlen_d,
    output logic [2:0]            arsize_d,
    output logic [1:0]            arburst_d,
    output logic [1:0]            arlock_d,
    output logic [1:0]            arcache_d,
    output logic [2:0]            arprot_d,
    output logic                  rd_trn_en,
    // read beats from master
    input  logic [data_width-1:0] rdata_d,
    input  logic [1:0]            rresp_d,
    input  logic [7:0]            rid_d,
    input  logic                  rd_rsp_en_d,
    input  logic                  r_last_d,
    // response stream
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_is_read,
    output logic [3:0]            rsp_id,
    output logic [1:0]            rsp_resp,
    output logic [data_width-1:0] rsp_data,
    output logic                  rsp_last,
    output logic                  rsp_overflow
);

    localparam int RSP_W = data_width + c_RSP_META_W;

    state_t     state_q, state_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;

    logic             w_accept;
    logic             w_wrap_bad;
    logic             w_start_wr;
    logic             w_start_rd;
    logic             w_push;
    logic [RSP_W-1:0] w_push_entry;
    logic [RSP_W-1:0] w_pop_entry;
    logic             w_fifo_empty;
    logic             w_unused;

    // Only the low ID bits are carried through to the response stream.
    assign w_unused = &{1'b0, rid_d[7:4]};

    assign cmd_ready  = (state_q == IDLE) && !ARst;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_wrap_bad = (cmd_burst == c_BURST_WRAP) && !wrap_len_legal(cmd_len);
    assign w_start_wr = w_accept && cmd_rw && !w_wrap_bad;
    assign w_start_rd = w_accept && !cmd_rw && !w_wrap_bad;

    // ------------------------------------------------------------------
    // Next-state, beat counting and response capture
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        w_push       = 1'b0;
        w_push_entry = '0;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    if (w_wrap_bad) begin
                        // answered locally; the controller never leaves IDLE
                        w_push       = 1'b1;
                        w_push_entry = {~cmd_rw, cmd_id, c_RESP_SLVERR,
                                        {data_width{1'b0}}, 1'b1};
                    end else if (cmd_rw) begin
                        state_d = WR_ISSUE;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            WR_ISSUE: begin
                state_d = WR_DATA;
            end
            WR_DATA: begin
                // an ack with no data presented consumes nothing
                if (wbeat_ack && wd_valid) begin
                    if (beat_cnt_q == awlen_d) begin
                        beat_cnt_d = '0;
                        state_d    = WR_RESP;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            WR_RESP: begin
                if (wr_rsp_en_d) begin
                    w_push       = 1'b1;
                    w_push_entry = {1'b0, bid_d, bresp_d, {data_width{1'b0}}, 1'b1};
                    state_d      = IDLE;
                end
            end
            RD_ISSUE: begin
                state_d = RD_DATA;
            end
            RD_DATA: begin
                if (rd_rsp_en_d) begin
                    w_push       = 1'b1;
                    w_push_entry = {1'b1, rid_d[3:0], rresp_d, rdata_d, r_last_d};
                    if (r_last_d) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and captured request fields
    // ------------------------------------------------------------------
    always_ff @(posedge AClk or posedge ARst) begin
        if (ARst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            TXN_ID_W_d <= '0;
            awaddr_d   <= '0;
            awlen_d    <= '0;
            awsize_d   <= '0;
            awburst_d  <= '0;
            TXN_ID_R_d <= '0;
            araddr_d   <= '0;
            arlen_d    <= '0;
            arsize_d   <= '0;
            arburst_d  <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            if (w_start_wr) begin
                TXN_ID_W_d <= cmd_id;
                awaddr_d   <= cmd_addr;
                awlen_d    <= cmd_len;
                awsize_d   <= cmd_size;
                awburst_d  <= cmd_burst;
            end
            if (w_start_rd) begin
                TXN_ID_R_d <= cmd_id;
                araddr_d   <= cmd_addr;
                arlen_d    <= cmd_len;
                arsize_d   <= cmd_size;
                arburst_d  <= cmd_burst;
            end
        end
    end

    // ------------------------------------------------------------------
    // Request strobes and write-data pass-through
    // ------------------------------------------------------------------
    assign wr_trn_en = (state_q == WR_ISSUE);
    assign rd_trn_en = (state_q == RD_ISSUE);
    assign wd_ready  = (state_q == WR_DATA) && wbeat_ack;
    assign wdata_d   = (state_q == WR_DATA) ? wd_data : '0;
    assign wstrb_d   = (state_q == WR_DATA) ? wd_strb : '0;

    assign awlock_d  = c_AXLOCK;
    assign awcache_d = c_AXCACHE;
    assign awprot_d  = c_AXPROT;
    assign arlock_d  = c_AXLOCK;
    assign arcache_d = c_AXCACHE;
    assign arprot_d  = c_AXPROT;

    // ------------------------------------------------------------------
    // Response buffer
    // ------------------------------------------------------------------
    axi_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i       (AClk),
        .rst_i       (ARst),
        .push_i      (w_push),
        .push_data_i (w_push_entry),
        .pop_i       (rsp_valid && rsp_ready),
        .pop_data_o  (w_pop_entry),
        .empty_o     (w_fifo_empty),
        .overflow_o  (rsp_overflow)
    );

    assign rsp_valid = !w_fifo_empty;
    // Fields read as zero while nothing is buffered.
    assign {rsp_is_read, rsp_id, rsp_resp, rsp_data, rsp_last} =
        rsp_valid ? w_pop_entry : '0;

endmodule : axi_master_decoder
`default_nettype wire

// File: tb/tb_axi_master_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_master_decoder
//  Description : Self-checking bench for axi_master_decoder. A table of
//                command records drives complete transactions; expected
//                responses go into a scoreboard queue and are compared as the
//                DUT hands them out. Hand-written sequences cover ignored
//                acks, FIFO overflow, reset mid-burst and full push+pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_master_decoder;

    logic        AClk = 1'b0;
    logic        ARst;
    logic        cmd_valid, cmd_ready, cmd_rw;
    logic [3:0]  cmd_id;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic        wd_valid, wd_ready;
    logic [63:0] wd_data;
    logic [7:0]  wd_strb;
    logic        wbeat_ack;
    logic [3:0]  TXN_ID_W_d;
    logic [31:0] awaddr_d;
    logic [7:0]  awlen_d;
    logic [2:0]  awsize_d;
    logic [1:0]  awburst_d, awlock_d, awcache_d;
    logic [2:0]  awprot_d;
    logic [63:0] wdata_d;
    logic [7:0]  wstrb_d;
    logic        wr_trn_en;
    logic [1:0]  bresp_d;
    logic [3:0]  bid_d;
    logic        wr_rsp_en_d;
    logic [3:0]  TXN_ID_R_d;
    logic [31:0] araddr_d;
    logic [7:0]  arlen_d;
    logic [2:0]  arsize_d;
    logic [1:0]  arburst_d, arlock_d, arcache_d;
    logic [2:0]  arprot_d;
    logic        rd_trn_en;
    logic [63:0] rdata_d;
    logic [1:0]  rresp_d;
    logic [7:0]  rid_d;
    logic        rd_rsp_en_d, r_last_d;
    logic        rsp_valid, rsp_ready, rsp_is_read;
    logic [3:0]  rsp_id;
    logic [1:0]  rsp_resp;
    logic [63:0] rsp_data;
    logic        rsp_last, rsp_overflow;

    axi_master_decoder #(
        .addr_width (32),
        .data_width (64),
        .RSP_DEPTH  (4)
    ) dut (
        .AClk (AClk), .ARst (ARst),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_rw (cmd_rw),
        .cmd_id (cmd_id), .cmd_addr (cmd_addr), .cmd_len (cmd_len),
        .cmd_size (cmd_size), .cmd_burst (cmd_burst),
        .wd_valid (wd_valid), .wd_ready (wd_ready), .wd_data (wd_data),
        .wd_strb (wd_strb), .wbeat_ack (wbeat_ack),
        .TXN_ID_W_d (TXN_ID_W_d), .awaddr_d (awaddr_d), .awlen_d (awlen_d),
        .awsize_d (awsize_d), .awburst_d (awburst_d), .awlock_d (awlock_d),
        .awcache_d (awcache_d), .awprot_d (awprot_d), .wdata_d (wdata_d),
        .wstrb_d (wstrb_d), .wr_trn_en (wr_trn_en),
        .bresp_d (bresp_d), .bid_d (bid_d), .wr_rsp_en_d (wr_rsp_en_d),
        .TXN_ID_R_d (TXN_ID_R_d), .araddr_d (araddr_d), .arlen_d (arlen_d),
        .arsize_d (arsize_d), .arburst_d (arburst_d), .arlock_d (arlock_d),
        .arcache_d (arcache_d), .arprot_d (arprot_d), .rd_trn_en (rd_trn_en),
        .rdata_d (rdata_d), .rresp_d (rresp_d), .rid_d (rid_d),
        .rd_rsp_en_d (rd_rsp_en_d), .r_last_d (r_last_d),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready),
        .rsp_is_read (rsp_is_read), .rsp_id (rsp_id), .rsp_resp (rsp_resp),
        .rsp_data (rsp_data), .rsp_last (rsp_last), .rsp_overflow (rsp_overflow)
    );

    always #5 AClk = ~AClk;

    int total = 0;
    int bad   = 0;

    // {is_read, id, resp, data, last}
    logic [71:0] exp_q[$];

    int wr_pulses = 0;
    int rd_pulses = 0;
    int wd_beats  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Event counters and response scoreboard, sampled mid-cycle.
    always @(negedge AClk) begin
        if (wr_trn_en) wr_pulses++;
        if (rd_trn_en) rd_pulses++;
        if (wd_valid && wd_ready) wd_beats++;
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", rsp_valid, 1'b0);
            end else begin
                chk("rsp_entry", {rsp_is_read, rsp_id, rsp_resp, rsp_data, rsp_last},
                    exp_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue_cmd(input logic rw, input logic [3:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge AClk); #1;
            n++;
        end
        chk("cmd_ready_wait", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_rw = rw; cmd_id = id; cmd_addr = addr;
        cmd_len = len; cmd_burst = burst; cmd_size = 3'd3;
        @(posedge AClk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [1:0] bresp,
                             input logic exp_err, input int bubbles);
        int d0;
        logic [63:0] pat;
        d0 = wd_beats;
        issue_cmd(1'b1, id, addr, len, burst);
        if (exp_err) begin
            exp_q.push_back({1'b0, id, 2'b10, 64'h0, 1'b1});
            chk("err_stays_idle", cmd_ready, 1'b1);
            @(posedge AClk); #1;
        end else begin
            chk("wr_issue_pulse", wr_trn_en, 1'b1);
            @(posedge AClk); #1;
            chk("awaddr_held", awaddr_d, addr);
            chk("awlen_held", awlen_d, len);
            for (int b = 0; b < bubbles; b++) begin
                wd_valid = 1'b0; wbeat_ack = 1'b1; wd_data = 64'hDEAD;
                @(posedge AClk); #1;
            end
            for (int i = 0; i <= int'(len); i++) begin
                pat = {32'hA5000000 | 32'(id), 32'(i)};
                wd_valid = 1'b1; wbeat_ack = 1'b1; wd_data = pat; wd_strb = 8'hF0 ^ 8'(i);
                #1;
                chk("wd_ready_beat", wd_ready, 1'b1);
                chk("wdata_pass", {wstrb_d, wdata_d}, {8'hF0 ^ 8'(i), pat});
                @(posedge AClk); #1;
            end
            wd_valid = 1'b0; wbeat_ack = 1'b0;
            wr_rsp_en_d = 1'b1; bid_d = id; bresp_d = bresp;
            exp_q.push_back({1'b0, id, bresp, 64'h0, 1'b1});
            @(posedge AClk); #1;
            wr_rsp_en_d = 1'b0;
            chk("wr_back_idle", cmd_ready, 1'b1);
        end
        chk("wd_beats_consumed", wd_beats - d0, exp_err ? 0 : int'(len) + 1);
    endtask

    task automatic run_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [1:0] rresp,
                            input logic exp_err, input int keep, input int ready_at);
        logic [63:0] pat;
        issue_cmd(1'b0, id, addr, len, burst);
        if (exp_err) begin
            exp_q.push_back({1'b1, id, 2'b10, 64'h0, 1'b1});
            chk("err_stays_idle", cmd_ready, 1'b1);
            @(posedge AClk); #1;
        end else begin
            chk("rd_issue_pulse", rd_trn_en, 1'b1);
            @(posedge AClk); #1;
            chk("araddr_held", araddr_d, addr);
            chk("arlen_held", arlen_d, len);
            for (int i = 0; i <= int'(len); i++) begin
                if (i == ready_at) rsp_ready = 1'b1;
                pat = {32'hC0DE0000 | 32'(id), 32'(i * 3 + 1)};
                rd_rsp_en_d = 1'b1; rdata_d = pat; rresp_d = rresp;
                rid_d = {4'hA, id}; r_last_d = (i == int'(len));
                if (i < keep) exp_q.push_back({1'b1, id, rresp, pat, r_last_d});
                @(posedge AClk); #1;
            end
            rd_rsp_en_d = 1'b0; r_last_d = 1'b0;
            chk("rd_back_idle", cmd_ready, 1'b1);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge AClk); #1;
            n++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("rsp_valid_empty", rsp_valid, 1'b0);
    endtask

    typedef struct {
        logic        rw;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [1:0]  resp;
        logic        exp_err;
        int          exp_wr;
        int          exp_rd;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int w0, r0;
        ARst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_id = '0; cmd_addr = '0;
        cmd_len = '0; cmd_size = '0; cmd_burst = '0; wd_valid = 1'b0; wd_data = '0;
        wd_strb = '0; wbeat_ack = 1'b0; bresp_d = '0; bid_d = '0; wr_rsp_en_d = 1'b0;
        rdata_d = '0; rresp_d = '0; rid_d = '0; rd_rsp_en_d = 1'b0; r_last_d = 1'b0;
        rsp_ready = 1'b1;

        //            rw    id     addr          len    burst  resp   err   wr rd
        vecs[0] = '{1'b1, 4'd5,  32'h0000_1000, 8'd3,  2'b01, 2'b00, 1'b0, 1, 0};
        vecs[1] = '{1'b0, 4'd3,  32'h0000_2000, 8'd7,  2'b01, 2'b00, 1'b0, 0, 1};
        vecs[2] = '{1'b1, 4'd6,  32'h0000_1100, 8'd2,  2'b10, 2'b00, 1'b1, 0, 0};
        vecs[3] = '{1'b0, 4'd4,  32'h0000_2100, 8'd5,  2'b10, 2'b00, 1'b1, 0, 0};
        vecs[4] = '{1'b1, 4'd10, 32'h0000_1200, 8'd3,  2'b10, 2'b01, 1'b0, 1, 0};
        vecs[5] = '{1'b0, 4'd12, 32'h0000_2200, 8'd0,  2'b00, 2'b11, 1'b0, 0, 1};
        vecs[6] = '{1'b1, 4'd15, 32'h0000_1300, 8'd0,  2'b00, 2'b11, 1'b0, 1, 0};
        vecs[7] = '{1'b0, 4'd1,  32'h0000_2300, 8'd15, 2'b10, 2'b10, 1'b0, 0, 1};

        // reset state
        repeat (3) @(posedge AClk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_overflow", rsp_overflow, 1'b0);
        chk("rst_trn_en", {wr_trn_en, rd_trn_en, wd_ready}, 3'b000);
        chk("rst_aw_fields", {TXN_ID_W_d, awaddr_d, awlen_d, awburst_d}, '0);
        chk("rst_ar_fields", {TXN_ID_R_d, araddr_d, arlen_d, arburst_d}, '0);
        ARst = 1'b0;
        @(posedge AClk); #1;
        chk("idle_cmd_ready", cmd_ready, 1'b1);
        chk("attr_const", {awlock_d, awcache_d, awprot_d, arlock_d, arcache_d, arprot_d}, '0);

        // table-driven transactions
        for (int v = 0; v < 8; v++) begin
            w0 = wr_pulses; r0 = rd_pulses;
            if (vecs[v].rw)
                run_write(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].burst,
                          vecs[v].resp, vecs[v].exp_err, 0);
            else
                run_read(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].burst,
                         vecs[v].resp, vecs[v].exp_err, 256, -1);
            @(posedge AClk); #1;
            chk("wr_trn_pulses", wr_pulses - w0, vecs[v].exp_wr);
            chk("rd_trn_pulses", rd_pulses - r0, vecs[v].exp_rd);
        end
        drain();

        // acks without write data must be ignored
        run_write(4'd9, 32'h0000_4000, 8'd3, 2'b01, 2'b00, 1'b0, 2);
        drain();

        // overflow: 8 read beats into a 4-entry FIFO with no draining
        rsp_ready = 1'b0;
        run_read(4'd2, 32'h0000_2400, 8'd7, 2'b01, 2'b00, 1'b0, 4, -1);
        chk("overflow_set", rsp_overflow, 1'b1);
        chk("overflow_valid", rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        drain();
        chk("overflow_sticky", rsp_overflow, 1'b1);

        // reset in the middle of a write burst, after 2 of 4 beats
        issue_cmd(1'b1, 4'd7, 32'h0000_3000, 8'd3, 2'b01);
        @(posedge AClk); #1;
        for (int i = 0; i < 2; i++) begin
            wd_valid = 1'b1; wbeat_ack = 1'b1; wd_data = 64'(i);
            @(posedge AClk); #1;
        end
        wd_data = 64'h1234; #2;
        ARst = 1'b1; #1;
        chk("midrst_aw_fields", {TXN_ID_W_d, awaddr_d, awlen_d, awburst_d}, '0);
        chk("midrst_strobes", {wr_trn_en, rd_trn_en, wd_ready, cmd_ready}, 4'b0000);
        chk("midrst_wdata", {wstrb_d, wdata_d}, '0);
        chk("midrst_rsp", {rsp_valid, rsp_overflow}, 2'b00);
        @(posedge AClk); #1;
        wd_valid = 1'b0; wbeat_ack = 1'b0; #2;
        ARst = 1'b0;
        @(posedge AClk); #1;
        run_write(4'd8, 32'h0000_3100, 8'd3, 2'b01, 2'b00, 1'b0, 0);
        drain();

        // push into a full FIFO while it is being popped
        rsp_ready = 1'b0;
        run_read(4'd11, 32'h0000_5000, 8'd4, 2'b01, 2'b01, 1'b0, 256, 4);
        chk("full_pushpop_no_ovf", rsp_overflow, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_axi_master_decoder
`default_nettype wire
